// File: rtl/wb_sequencer_if.sv
// rtl/wb_sequencer_if.sv - write-back sequencer request/response bundle
interface wb_sequencer_if;
  logic       alu_req;
  logic [4:0] alu_rd;
  logic [1:0] alu_kind;
  logic       alu_rdy;
  logic       mem_req;
  logic [4:0] mem_rd;
  logic       mem_rdy;
  logic [1:0] wb_sel;
  logic       reg_wr;
  logic [4:0] wr_rd;
  logic       busy;

  modport master (
    output alu_req, alu_rd, alu_kind, mem_req, mem_rd,
    input  alu_rdy, mem_rdy, wb_sel, reg_wr, wr_rd, busy
  );

  modport slave (
    input  alu_req, alu_rd, alu_kind, mem_req, mem_rd,
    output alu_rdy, mem_rdy, wb_sel, reg_wr, wr_rd, busy
  );
endinterface

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - arbitrates ALU and load write-backs into one register-file port
module wb_sequencer #(
  parameter int MEM_LAT = 2
) (
  input logic           clk,
  input logic           reset_n,
  wb_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_WB, ALU_HOLD} state_t;

  localparam bit LAT1 = (MEM_LAT == 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [4:0] ld_rd, buf_rd, ld_rd_now;
  logic [1:0] buf_sel, alu_sel;
  logic       alu_acc, mem_acc, ld_fire, ld_pend;

  always_comb begin
    ld_pend     = (state != IDLE);
    bus.busy    = ld_pend;
    bus.mem_rdy = (state == IDLE);
    // WAW stall keeps a younger ALU write from landing before the older load
    bus.alu_rdy = (state != ALU_HOLD) &&
                  !(ld_pend && (ld_rd != 5'd0) && (ld_rd == bus.alu_rd));
    mem_acc     = bus.mem_req && bus.mem_rdy;
    alu_acc     = bus.alu_req && bus.alu_rdy;
    alu_sel     = (bus.alu_kind == 2'b01) ? 2'b00 : bus.alu_kind;
    ld_fire     = (state == IDLE && mem_acc && LAT1) ||
                  (state == LOAD_WAIT && cnt == 4'd1);
    ld_rd_now   = (state == IDLE) ? bus.mem_rd : ld_rd;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_acc) begin
          if (LAT1) begin
            state_nxt = alu_acc ? ALU_HOLD : LOAD_WB;
          end else begin
            state_nxt = LOAD_WAIT;
            cnt_nxt   = 4'(MEM_LAT - 1);
          end
        end
      end
      LOAD_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = alu_acc ? ALU_HOLD : LOAD_WB;
      end
      LOAD_WB:  state_nxt = IDLE;
      ALU_HOLD: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ld_rd      <= 5'd0;
      buf_rd     <= 5'd0;
      buf_sel    <= 2'b00;
      bus.reg_wr <= 1'b0;
      bus.wb_sel <= 2'b00;
      bus.wr_rd  <= 5'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bus.reg_wr <= 1'b0;
      if (mem_acc) ld_rd <= bus.mem_rd;
      // Captured on every ALU accept; only read back when a load collided
      if (alu_acc) begin
        buf_rd  <= bus.alu_rd;
        buf_sel <= alu_sel;
      end
      if (ld_fire) begin
        bus.wb_sel <= 2'b01;
        bus.wr_rd  <= ld_rd_now;
        bus.reg_wr <= (ld_rd_now != 5'd0);
      end else if (state == ALU_HOLD) begin
        bus.wb_sel <= buf_sel;
        bus.wr_rd  <= buf_rd;
        bus.reg_wr <= (buf_rd != 5'd0);
      end else if (alu_acc) begin
        bus.wb_sel <= alu_sel;
        bus.wr_rd  <= bus.alu_rd;
        bus.reg_wr <= (bus.alu_rd != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - scoreboard bench for wb_sequencer at MEM_LAT 2 and 1
module tb_wb_sequencer;

  typedef struct {
    logic [1:0] sel;
    logic [4:0] rd;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_sequencer_if ia ();
  wb_sequencer_if ib ();

  wb_sequencer #(.MEM_LAT(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  wb_sequencer #(.MEM_LAT(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ia.reg_wr === 1'b1) begin
      if (qa.size() == 0) chk("a_stray_write", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_wb_sel", int'(ia.wb_sel), int'(e.sel));
        chk("a_wr_rd", int'(ia.wr_rd), int'(e.rd));
        chk("a_wr_cycle", cyc, e.cyc);
      end
    end
    if (ib.reg_wr === 1'b1) begin
      if (qb.size() == 0) chk("b_stray_write", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_wb_sel", int'(ib.wb_sel), int'(e.sel));
        chk("b_wr_rd", int'(ib.wr_rd), int'(e.rd));
        chk("b_wr_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    ia.alu_req = 0; ia.alu_rd = 0; ia.alu_kind = 0; ia.mem_req = 0; ia.mem_rd = 0;
    ib.alu_req = 0; ib.alu_rd = 0; ib.alu_kind = 0; ib.mem_req = 0; ib.mem_rd = 0;
    repeat (2) tick();
    chk("rst_reg_wr", int'(ia.reg_wr), 0);
    chk("rst_wb_sel", int'(ia.wb_sel), 0);
    chk("rst_wr_rd", int'(ia.wr_rd), 0);
    reset_n = 1'b1;
    tick();
    chk("rel_alu_rdy", int'(ia.alu_rdy), 1);
    chk("rel_mem_rdy", int'(ia.mem_rdy), 1);
    chk("rel_busy", int'(ia.busy), 0);

    // load rd=5, write two cycles later
    t = cyc;
    ia.mem_req = 1; ia.mem_rd = 5;
    #1 chk("ld_mem_rdy_T", int'(ia.mem_rdy), 1);
    qa.push_back('{2'b01, 5'd5, t + 2});
    tick(); ia.mem_req = 0;
    #1 chk("ld_mem_rdy_T1", int'(ia.mem_rdy), 0);
    chk("ld_busy_T1", int'(ia.busy), 1);
    tick();
    #1 chk("ld_mem_rdy_T2", int'(ia.mem_rdy), 0);
    tick();
    #1 chk("ld_mem_rdy_T3", int'(ia.mem_rdy), 1);
    chk("ld_busy_T3", int'(ia.busy), 0);

    // back-to-back ALU writes, every kind mapping
    t = cyc; ia.alu_req = 1; ia.alu_kind = 2'b10; ia.alu_rd = 7;
    #1 chk("alu_rdy_k10", int'(ia.alu_rdy), 1);
    qa.push_back('{2'b10, 5'd7, t + 1});
    tick(); t = cyc; ia.alu_kind = 2'b01; ia.alu_rd = 2;
    qa.push_back('{2'b00, 5'd2, t + 1});
    tick(); t = cyc; ia.alu_kind = 2'b11; ia.alu_rd = 6;
    qa.push_back('{2'b11, 5'd6, t + 1});
    tick(); t = cyc; ia.alu_kind = 2'b00; ia.alu_rd = 1;
    qa.push_back('{2'b00, 5'd1, t + 1});
    tick(); ia.alu_req = 0;
    tick();

    // WAW stall on rd=9
    t = cyc; ia.mem_req = 1; ia.mem_rd = 9;
    qa.push_back('{2'b01, 5'd9, t + 2});
    tick(); ia.mem_req = 0; ia.alu_req = 1; ia.alu_kind = 2'b00; ia.alu_rd = 9;
    #1 chk("waw_alu_rdy_T1", int'(ia.alu_rdy), 0);
    tick();
    #1 chk("waw_alu_rdy_T2", int'(ia.alu_rdy), 0);
    tick(); t = cyc;
    #1 chk("waw_alu_rdy_T3", int'(ia.alu_rdy), 1);
    qa.push_back('{2'b00, 5'd9, t + 1});
    tick(); ia.alu_req = 0;
    tick();

    // rd=0 ALU collides with load write: buffered, slot consumed, no reg_wr
    t = cyc; ia.mem_req = 1; ia.mem_rd = 9;
    qa.push_back('{2'b01, 5'd9, t + 2});
    tick(); ia.mem_req = 0; ia.alu_req = 1; ia.alu_kind = 2'b10; ia.alu_rd = 0;
    #1 chk("rd0_alu_rdy", int'(ia.alu_rdy), 1);
    tick(); ia.alu_req = 0;
    #1 chk("hold_alu_rdy", int'(ia.alu_rdy), 0);
    chk("hold_busy", int'(ia.busy), 1);
    tick();
    #1 chk("rd0_reg_wr", int'(ia.reg_wr), 0);
    chk("rd0_wb_sel", int'(ia.wb_sel), 2);
    chk("rd0_wr_rd", int'(ia.wr_rd), 0);
    chk("rd0_busy", int'(ia.busy), 0);
    tick();
    chk("idle_hold_sel", int'(ia.wb_sel), 2);

    // reset one cycle before the load write is due
    ia.mem_req = 1; ia.mem_rd = 12;
    tick(); ia.mem_req = 0;
    reset_n = 1'b0;
    #1 chk("mid_rst_reg_wr", int'(ia.reg_wr), 0);
    chk("mid_rst_wb_sel", int'(ia.wb_sel), 0);
    chk("mid_rst_wr_rd", int'(ia.wr_rd), 0);
    chk("mid_rst_busy", int'(ia.busy), 0);
    tick(); reset_n = 1'b1;
    #1 chk("post_rst_alu_rdy", int'(ia.alu_rdy), 1);
    chk("post_rst_mem_rdy", int'(ia.mem_rdy), 1);
    tick();
    chk("post_rst_reg_wr", int'(ia.reg_wr), 0);
    chk("post_rst_busy", int'(ia.busy), 0);

    // MEM_LAT=1: simultaneous load and ALU collide, ALU slips a cycle
    t = cyc; ib.mem_req = 1; ib.mem_rd = 3; ib.alu_req = 1; ib.alu_kind = 2'b00; ib.alu_rd = 4;
    #1 chk("b_alu_rdy_T", int'(ib.alu_rdy), 1);
    chk("b_mem_rdy_T", int'(ib.mem_rdy), 1);
    qb.push_back('{2'b01, 5'd3, t + 1});
    qb.push_back('{2'b00, 5'd4, t + 2});
    tick(); ib.mem_req = 0; ib.alu_req = 0;
    #1 chk("b_alu_rdy_T1", int'(ib.alu_rdy), 0);
    chk("b_mem_rdy_T1", int'(ib.mem_rdy), 0);
    tick();
    #1 chk("b_alu_rdy_T2", int'(ib.alu_rdy), 1);
    chk("b_mem_rdy_T2", int'(ib.mem_rdy), 1);
    t = cyc; ib.mem_req = 1; ib.mem_rd = 8;
    qb.push_back('{2'b01, 5'd8, t + 1});
    tick(); ib.mem_req = 0;
    #1 chk("b_ld_mem_rdy_T1", int'(ib.mem_rdy), 0);
    tick();
    #1 chk("b_ld_mem_rdy_T2", int'(ib.mem_rdy), 1);

    repeat (3) tick();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
